vote_session_ctrl: RTL and testbench
====================================

// Module: vote_session_ctrl
// PURPOSE
//  Sequences one voting session for the 4-member panel (chair = voter 0).
//  - Opens a timed collection window on start.
//  - Latches each member's first "yes" press.
//  - Closes early when all four have voted.
//  - Evaluates the chair-weighted majority and holds the verdict on the LED until the next session.
//  - Sits between the debounced panel buttons and the result LED.
// PARAMETERS
//  WINDOW_CYCLES  50_000_000  collection window length in clk cycles (1 s @ 50 MHz); must be >= 2
//  CNT_W          $clog2(WINDOW_CYCLES)  width of the window down-counter (derived, do not override)
// PORTS
//  clk       in   1      system clock; single clock domain
//  rst       in   1      synchronous, active-high reset
//  start     in   1      1-cycle pulse from debounced start key, already in clk domain
//  abort     in   1      1-cycle pulse; cancels the session in progress
//  vote      in   4      raw member buttons, active-high, asynchronous; bit 0 = chair
//  busy      out  1      1 while collecting or tallying
//  done      out  1      1 while a verdict is held (SHOW)
//  voted     out  4      latched yes-votes for the current or last session
//  remain    out  CNT_W  cycles left in the window; 0 outside COLLECT
//  led       out  1      verdict: 1 = motion passes; valid only when done = 1, else 0
// BEHAVIOUR
//  Reset: state = IDLE; busy = done = led = 0; voted = 0; remain = 0; synchroniser and edge flops = 0.
//  Input path: vote passes through a 2-FF synchroniser, then a rising-edge detector giving vote_rise[3:0].
//    A press reaches vote_rise 3 cycles after the raw edge.
//    A button held across session start does not count until it is released and pressed again.
//  States: IDLE -> COLLECT -> TALLY -> SHOW; SHOW -> COLLECT on start.
//  IDLE: start -> COLLECT next cycle; voted <= 0; remain <= WINDOW_CYCLES-1.
//  COLLECT: voted <= voted | vote_rise; a voter's bit never clears within a session.
//    remain decrements by 1 per cycle.
//    Leave for TALLY when remain == 0, or when (voted | vote_rise) == 4'b1111.
//    A rise in the final cycle is counted. start is ignored in COLLECT.
//  TALLY: exactly 1 cycle.
//    led_r <= (v0&v1)|(v0&v2)|(v0&v3)|(v1&v2&v3), using the final voted vector.
//    The chair breaks a 2-2 tie; abstention counts as no.
//  SHOW: done = 1; led = led_r; voted is held. start -> COLLECT with voted, led, done cleared next cycle.
//  abort: in COLLECT, TALLY or SHOW -> IDLE next cycle; voted, led, done, remain cleared.
//    In IDLE, abort has no effect.
//  Simultaneous start and abort: abort wins.
//  Simultaneous early-close and abort: abort wins.
//  rst mid-session: all state returns to reset values on the next edge; no partial verdict is shown.
//  busy = (state == COLLECT) || (state == TALLY).
//  Outputs are registered or decoded from registered state only; no combinational path from any input to any output.
// STRUCTURE
//  Shared package/include vote_pkg:
//    state encoding S_IDLE, S_COLLECT, S_TALLY, S_SHOW (2-bit);
//    N_VOTERS = 4; CHAIR_IDX = 0;
//    function vote_pass(input [3:0] v) holding the verdict equation, also used by the scoreboard.
//  Sub-module vote_edge_sync (WIDTH = 4): 2-FF synchroniser plus rising-edge detector; clk/rst as above.
//  Top block: FSM, window counter, vote latch, verdict register.
// TESTING  (WINDOW_CYCLES = 16 in simulation)
//  1 Early close, pass: start; press v0 and v2 at cycle 3, v1 and v3 at cycle 5.
//    -> voted = 1111, TALLY before remain reaches 0, done = 1, led = 1.
//  2 Tie, chair yes: v0 and v1 press; window expires.
//    -> exactly 16 COLLECT cycles, then TALLY, then SHOW with led = 1.
//  3 Tie, chair absent: v2 and v3 press -> led = 0.
//    Re-run with v1, v2 and v3 pressing -> led = 1.
//  4 Held button and duplicate presses: v1 held high through start, never released -> voted[1] = 0.
//    v2 pressed 3 times -> voted[2] = 1 only.
//  5 Boundaries:
//    a) vote rise on the cycle with remain == 0 -> counted.
//    b) start during COLLECT -> ignored; remain keeps decrementing.
//    c) start and abort in the same cycle in SHOW -> IDLE; led = 0.
//  6 Reset mid-COLLECT: assert rst at remain = 7 with voted = 0101.
//    -> next cycle all outputs 0, state IDLE.
//    A fresh start then runs a full 16-cycle window.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding, panel constants and verdict equation
package vote_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_TALLY   = 2'd2,
    S_SHOW    = 2'd3
  } state_t;

  localparam int N_VOTERS  = 4;
  localparam int CHAIR_IDX = 0;

  // Chair plus any one other member, or all three ordinary members, carries the motion.
  function automatic logic vote_pass(input logic [N_VOTERS-1:0] v);
    return (v[CHAIR_IDX] & v[1]) | (v[CHAIR_IDX] & v[2]) | (v[CHAIR_IDX] & v[3]) |
           (v[1] & v[2] & v[3]);
  endfunction

endpackage

// File: rtl/vote_edge_sync.sv
// rtl/vote_edge_sync.sv - two-flop synchroniser with registered rising-edge pulse
module vote_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;
  logic [WIDTH-1:0] prev;

  // Resynchronise the raw buttons, keep last level, emit a one-cycle pulse per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      stage2 <= '0;
      prev   <= '0;
      rise   <= '0;
    end else begin
      stage1 <= level;
      stage2 <= stage1;
      prev   <= stage2;
      rise   <= stage2 & ~prev;
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - voting session sequencer: window, vote latch, chair-weighted verdict
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter  int WINDOW_CYCLES = 50_000_000,
  localparam int CNT_W         = $clog2(WINDOW_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       vote,
  output logic             busy,
  output logic             done,
  output logic [3:0]       voted,
  output logic [CNT_W-1:0] remain,
  output logic             led
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [3:0]       voted_n;
  logic [CNT_W-1:0] remain_n;
  logic             led_r;
  logic             led_n;
  logic [3:0]       vote_rise;
  logic [3:0]       voted_all;

  vote_edge_sync #(.WIDTH(4)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (vote),
    .rise  (vote_rise)
  );

  assign voted_all = voted | vote_rise;

  // Session registers: state, window counter, latched votes and held verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      voted  <= '0;
      remain <= '0;
      led_r  <= 1'b0;
    end else begin
      state  <= state_n;
      voted  <= voted_n;
      remain <= remain_n;
      led_r  <= led_n;
    end
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_n  = state;
    voted_n  = voted;
    remain_n = remain;
    led_n    = led_r;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n  = S_COLLECT;
          voted_n  = '0;
          remain_n = LAST;
          led_n    = 1'b0;
        end
      end
      S_COLLECT: begin
        voted_n = voted_all;
        // The rise seen on the last window cycle is latched before closing.
        if (remain == '0 || voted_all == 4'b1111) begin
          state_n  = S_TALLY;
          remain_n = '0;
        end else begin
          remain_n = remain - CNT_W'(1);
        end
      end
      S_TALLY: begin
        state_n = S_SHOW;
        led_n   = vote_pass(voted);
      end
      S_SHOW: begin
        if (start) begin
          state_n  = S_COLLECT;
          voted_n  = '0;
          remain_n = LAST;
          led_n    = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n  = S_IDLE;
      voted_n  = '0;
      remain_n = '0;
      led_n    = 1'b0;
    end
  end

  assign busy = (state == S_COLLECT) || (state == S_TALLY);
  assign done = (state == S_SHOW);
  assign led  = done & led_r;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - scoreboard bench with randomized panel presses and reference model
module tb_vote_session_ctrl;

  localparam int W   = 16;
  localparam int CW  = $clog2(W);
  localparam int PRE = 4;   // plan index whose edge samples the start pulse
  localparam int L   = 24;  // plan length in cycles

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    vote;
  logic          busy;
  logic          done;
  logic [3:0]    voted;
  logic [CW-1:0] remain;
  logic          led;

  vote_session_ctrl #(.WINDOW_CYCLES(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .vote   (vote),
    .busy   (busy),
    .done   (done),
    .voted  (voted),
    .remain (remain),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] voted;
    logic       led;
    int         busy_cycles;
  } exp_t;

  exp_t sbq[$];
  exp_t got_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] lvl  [0:L-1];
  logic       strt [0:L-1];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every new verdict is compared with the oldest expected session result.
  int   bcnt   = 0;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_verdict: got done=1 expected no session pending");
      end else begin
        got_e = sbq.pop_front();
        check("sb_voted", int'(voted), int'(got_e.voted));
        check("sb_led", int'(led), int'(got_e.led));
        check("sb_busy_cycles", bcnt, got_e.busy_cycles);
      end
    end
    if (busy) bcnt++;
    else      bcnt = 0;
    done_q = done;
  end

  task automatic clear_plan();
    for (int j = 0; j < L; j++) lvl[j] = 4'b0000;
  endtask

  task automatic add_pulse(input int i, input int s, input int w);
    for (int j = s; j < s + w && j < L; j++) lvl[j][i] = 1'b1;
  endtask

  // Reference: a press first sampled at edge j is seen by the panel logic at edge j+3;
  // it counts if that lands on one of the W window edges PRE+1 .. PRE+W.
  task automatic model(output logic [3:0] v, output int close);
    int arr [4];
    v     = 4'b0000;
    close = PRE + W;
    for (int i = 0; i < 4; i++) begin
      arr[i] = -1;
      for (int j = 1; j < L; j++)
        if (arr[i] < 0 && lvl[j][i] && !lvl[j-1][i] && j + 3 >= PRE + 1 && j + 3 <= PRE + W)
          arr[i] = j + 3;
      if (arr[i] >= 0) v[i] = 1'b1;
    end
    if (v == 4'b1111) begin
      close = 0;
      for (int i = 0; i < 4; i++) if (arr[i] > close) close = arr[i];
    end
  endtask

  task automatic run_session(input int extra_pct);
    logic [3:0] ev;
    int         close;
    int         yes;
    int         e;
    exp_t       x;
    model(ev, close);
    yes = int'(ev[0]) + int'(ev[1]) + int'(ev[2]) + int'(ev[3]);
    x.voted       = ev;
    x.led         = (yes > 2) || (yes == 2 && ev[0]);
    x.busy_cycles = close - PRE + 1;
    for (int k = 0; k < L; k++)
      strt[k] = (k == PRE) || (k > PRE && k <= close && $urandom_range(0, 99) < extra_pct);
    sbq.push_back(x);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = k - 1;
        check("remain", int'(remain), (e >= PRE && e < close) ? (W - 1 - (e - PRE)) : 0);
        check("busy", int'(busy), int'(e >= PRE && e <= close));
      end
      vote  = lvl[k];
      start = strt[k];
    end
    @(negedge clk);
    start = 1'b0;
    vote  = 4'b0000;
    check("session_done", int'(done), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_voted"}, int'(voted), 0);
    check({tag, "_remain"}, int'(remain), 0);
    check({tag, "_led"}, int'(led), 0);
  endtask

  initial begin
    int mode;
    int found;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    vote  = 4'b0000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", int'(busy), 0);
    check("idle_abort_done", int'(done), 0);

    // early close, all four
    clear_plan();
    add_pulse(0, PRE + 3, 2); add_pulse(2, PRE + 3, 2);
    add_pulse(1, PRE + 5, 2); add_pulse(3, PRE + 5, 2);
    run_session(0);
    // 2-2 tie with chair, full window
    clear_plan();
    add_pulse(0, 6, 2); add_pulse(1, 8, 1);
    run_session(0);
    // 2-2 tie without chair
    clear_plan();
    add_pulse(2, 7, 2); add_pulse(3, 9, 3);
    run_session(0);
    // three ordinary members
    clear_plan();
    add_pulse(1, 5, 2); add_pulse(2, 10, 2); add_pulse(3, 12, 1);
    run_session(0);
    // held button across start, repeated presses
    clear_plan();
    add_pulse(1, 1, L);
    add_pulse(2, 6, 2); add_pulse(2, 10, 2); add_pulse(2, 14, 2);
    run_session(0);
    // rise landing on the remain==0 cycle counts, one cycle later does not
    clear_plan();
    add_pulse(3, 6, 2); add_pulse(0, PRE + W - 3, 2); add_pulse(1, PRE + W - 2, 2);
    run_session(0);
    // start pulses during the window are ignored
    clear_plan();
    add_pulse(0, 5, 2); add_pulse(2, 9, 2);
    run_session(40);

    // start and abort together in SHOW
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_all_zero("show_abort");

    // abort in the middle of COLLECT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote  = 4'b0001;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    vote  = 4'b0000;
    @(negedge clk);
    abort = 1'b0;
    check_all_zero("collect_abort");
    repeat (4) @(negedge clk);

    // reset at remain == 7 with voters 0 and 2 latched
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vote  = 4'b0101;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      @(negedge clk);
      if (remain == CW'(7)) found = 1;
    end
    check("reach_remain7", found, 1);
    check("voted_at_remain7", int'(voted), 5);
    rst  = 1'b1;
    vote = 4'b0000;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_plan();
    run_session(0);

    // randomized sessions
    for (int s = 0; s < 20; s++) begin
      clear_plan();
      for (int i = 0; i < 4; i++) begin
        mode = int'($urandom_range(0, 5));
        if (mode == 1 || mode == 2) add_pulse(i, int'($urandom_range(1, 20)), int'($urandom_range(1, 3)));
        if (mode == 3) begin
          add_pulse(i, int'($urandom_range(1, 10)), 1);
          add_pulse(i, int'($urandom_range(12, 21)), int'($urandom_range(1, 2)));
        end
        if (mode == 4) add_pulse(i, 1, L);
      end
      run_session(10);
    end

    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
